// File: rtl/id_gen_pkg.sv
// id_gen_pkg: definitions shared by the identifier generator.
//   - FSM state encoding (legacy-style localparams)
//   - ASCII bounds for letters and digits, default terminator character
//   - id_req_t: one identifier request as presented on the bus
//   - classification helpers used to validate a request
package id_gen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LETTER = 2'd1;
  localparam logic [1:0] ST_DIGIT  = 2'd2;
  localparam logic [1:0] ST_TERM   = 2'd3;

  localparam logic [7:0] ASCII_LC_A        = 8'h61;  // "a"
  localparam logic [7:0] ASCII_LC_Z        = 8'h7A;  // "z"
  localparam logic [7:0] ASCII_UC_A        = 8'h41;  // "A"
  localparam logic [7:0] ASCII_UC_Z        = 8'h5A;  // "Z"
  localparam logic [7:0] ASCII_0           = 8'h30;  // "0"
  localparam logic [7:0] ASCII_9           = 8'h39;  // "9"
  localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h20;  // space

  typedef struct packed {
    logic [3:0] letter_num;
    logic [3:0] digit_num;
    logic [7:0] base_letter;
    logic [7:0] base_digit;
  } id_req_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z)) ||
           ((c >= ASCII_UC_A) && (c <= ASCII_UC_Z));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  // A request needs at least one letter, a letter base, and a digit base
  // only when digits are actually requested.
  function automatic logic req_ok(input id_req_t r);
    return (r.letter_num != 4'd0) && is_letter(r.base_letter) &&
           ((r.digit_num == 4'd0) || is_digit(r.base_digit));
  endfunction

endpackage

// File: rtl/id_gen_if.sv
// id_gen_if: request/stream bundle of the identifier generator.
//   start, letter_num, digit_num, base_letter, base_digit : request side
//   char, valid, busy, done, err                          : stream side
// slave  = generator view, master = requester/consumer view.
interface id_gen_if;

  logic       start;
  logic [3:0] letter_num;
  logic [3:0] digit_num;
  logic [7:0] base_letter;
  logic [7:0] base_digit;
  logic [7:0] char;
  logic       valid;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  start, letter_num, digit_num, base_letter, base_digit,
    output char, valid, busy, done, err
  );

  modport master (
    output start, letter_num, digit_num, base_letter, base_digit,
    input  char, valid, busy, done, err
  );

endinterface

// File: rtl/id_char_next.sv
// id_char_next: combinational successor of a letter or digit.
//   cur : current character
//   nxt : next character; "z"->"a", "Z"->"A", "9"->"0", otherwise cur+1
module id_char_next
  import id_gen_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  // wrap at the top of each range, plain increment elsewhere
  always_comb begin
    nxt = cur + 8'd1;
    if (cur == ASCII_LC_Z) begin
      nxt = ASCII_LC_A;
    end else if (cur == ASCII_UC_Z) begin
      nxt = ASCII_UC_A;
    end else if (cur == ASCII_9) begin
      nxt = ASCII_0;
    end else begin
      nxt = cur + 8'd1;
    end
  end

endmodule

// File: rtl/id_gen.sv
// id_gen: emits an identifier as a character stream: letter_num letters
// counting up from base_letter, digit_num digits counting up from
// base_digit, then one TERM_CHAR with done.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : id_gen_if.slave (request in, registered char stream out)
// A new request is taken in IDLE or while the terminator is on the
// output, so back-to-back identifiers share a single terminator cycle.
module id_gen
  import id_gen_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  id_gen_if.slave  bus
);

  logic [1:0] state_r,      state_s;
  logic [7:0] char_r,       char_s;
  logic       valid_r,      valid_s;
  logic       busy_r,       busy_s;
  logic       done_r,       done_s;
  logic       err_r,        err_s;
  logic [3:0] letter_rem_r, letter_rem_s;  // letters still to come after char_r
  logic [3:0] digit_rem_r,  digit_rem_s;   // digits still to come after char_r
  logic [3:0] digit_num_r,  digit_num_s;
  logic [7:0] base_digit_r, base_digit_s;

  logic [7:0] char_next_s;
  id_req_t    req_s;
  logic       can_take_s;

  assign req_s = '{letter_num:  bus.letter_num,
                   digit_num:   bus.digit_num,
                   base_letter: bus.base_letter,
                   base_digit:  bus.base_digit};

  // the request window: idle, or the final (terminator) cycle of a stream
  assign can_take_s = (state_r == ST_IDLE) || (state_r == ST_TERM);

  id_char_next u_char_next (
    .cur (char_r),
    .nxt (char_next_s)
  );

  // next-state and next-output computation
  always_comb begin
    state_s      = state_r;
    char_s       = char_r;
    valid_s      = valid_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    err_s        = 1'b0;
    letter_rem_s = letter_rem_r;
    digit_rem_s  = digit_rem_r;
    digit_num_s  = digit_num_r;
    base_digit_s = base_digit_r;

    case (state_r)
      ST_IDLE: begin
        char_s  = TERM_CHAR;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      ST_LETTER: begin
        if (letter_rem_r != 4'd0) begin
          char_s       = char_next_s;
          letter_rem_s = letter_rem_r - 4'd1;
        end else if (digit_num_r != 4'd0) begin
          state_s     = ST_DIGIT;
          char_s      = base_digit_r;
          digit_rem_s = digit_num_r - 4'd1;
        end else begin
          state_s = ST_TERM;
          char_s  = TERM_CHAR;
          done_s  = 1'b1;
        end
      end
      ST_DIGIT: begin
        if (digit_rem_r != 4'd0) begin
          char_s      = char_next_s;
          digit_rem_s = digit_rem_r - 4'd1;
        end else begin
          state_s = ST_TERM;
          char_s  = TERM_CHAR;
          done_s  = 1'b1;
        end
      end
      ST_TERM: begin
        state_s = ST_IDLE;
        char_s  = TERM_CHAR;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        char_s  = TERM_CHAR;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase

    // a request overrides the idle/terminator follow-up computed above;
    // the first letter goes straight onto the output register
    if (can_take_s && bus.start) begin
      if (req_ok(req_s)) begin
        state_s      = ST_LETTER;
        char_s       = bus.base_letter;
        valid_s      = 1'b1;
        busy_s       = 1'b1;
        letter_rem_s = bus.letter_num - 4'd1;
        digit_rem_s  = 4'd0;
        digit_num_s  = bus.digit_num;
        base_digit_s = bus.base_digit;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // state and output registers, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      char_r       <= TERM_CHAR;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      letter_rem_r <= 4'd0;
      digit_rem_r  <= 4'd0;
      digit_num_r  <= 4'd0;
      base_digit_r <= 8'd0;
    end else begin
      state_r      <= state_s;
      char_r       <= char_s;
      valid_r      <= valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
      letter_rem_r <= letter_rem_s;
      digit_rem_r  <= digit_rem_s;
      digit_num_r  <= digit_num_s;
      base_digit_r <= base_digit_s;
    end
  end

  assign bus.char  = char_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_id_gen.sv
// tb_id_gen: scoreboard bench for id_gen. The driver pushes one expected
// output record per clock edge, derived from a list-based model of the
// identifier stream; a negedge monitor pops and compares.
module tb_id_gen;

  typedef struct packed {
    logic [7:0] ch;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;
  } rec_t;

  localparam logic [7:0] SP = 8'h20;

  logic clk;
  logic reset;
  id_gen_if bus ();

  id_gen #(.TERM_CHAR(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests  = 0;
  int   failed = 0;
  rec_t exp_q[$];
  rec_t stream[$];   // characters still owed after the one currently shown

  // current stimulus, kept by the bench for the model
  logic       m_reset;
  logic       m_start;
  logic [3:0] m_ln, m_dn;
  logic [7:0] m_bl, m_bd;

  function automatic logic m_is_letter(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A);
  endfunction

  function automatic logic m_is_digit(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // Model of one clock edge: what the outputs show after it.
  task automatic model_edge();
    rec_t r;
    rec_t it;
    int   lb, off;
    r = '{ch: SP, valid: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
    if (m_reset) begin
      stream.delete();
    end else begin
      if (stream.size() == 0 && m_start) begin
        if (m_ln != 4'd0 && m_is_letter(m_bl) && (m_dn == 4'd0 || m_is_digit(m_bd))) begin
          lb  = (m_bl >= 8'h61) ? 32'h61 : 32'h41;
          off = int'(m_bl) - lb;
          for (int i = 0; i < int'(m_ln); i++) begin
            it = '{ch: 8'(lb + (off + i) % 26), valid: 1'b1, busy: 1'b1, done: 1'b0, err: 1'b0};
            stream.push_back(it);
          end
          for (int i = 0; i < int'(m_dn); i++) begin
            it = '{ch: 8'(32'h30 + (int'(m_bd) - 32'h30 + i) % 10), valid: 1'b1, busy: 1'b1,
                   done: 1'b0, err: 1'b0};
            stream.push_back(it);
          end
          it = '{ch: SP, valid: 1'b1, busy: 1'b1, done: 1'b1, err: 1'b0};
          stream.push_back(it);
        end else begin
          r.err = 1'b1;
        end
      end
      if (stream.size() > 0) r = stream.pop_front();
    end
    exp_q.push_back(r);
  endtask

  // Apply one cycle of stimulus, then record the model's view of that edge.
  task automatic cyc(input logic r, input logic s, input logic [3:0] ln, input logic [3:0] dn,
                     input logic [7:0] bl, input logic [7:0] bd);
    m_reset = r; m_start = s; m_ln = ln; m_dn = dn; m_bl = bl; m_bd = bd;
    reset = r;
    bus.start = s; bus.letter_num = ln; bus.digit_num = dn;
    bus.base_letter = bl; bus.base_digit = bd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
  endtask

  // monitor: compare every cycle's outputs against the queued expectation
  always @(negedge clk) begin
    rec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.char !== e.ch || bus.valid !== e.valid || bus.busy !== e.busy ||
          bus.done !== e.done || bus.err !== e.err) begin
        failed++;
        $display("FAIL stream t=%0t: got char=%h valid=%b busy=%b done=%b err=%b, want char=%h valid=%b busy=%b done=%b err=%b",
                 $time, bus.char, bus.valid, bus.busy, bus.done, bus.err,
                 e.ch, e.valid, e.busy, e.done, e.err);
      end
    end
  end

  initial begin
    logic [3:0] ln, dn;
    logic [7:0] bl, bd;
    logic       r, s;

    // reset state
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 4'd2, 4'd0, "a", "0");   // reset beats start
    idle(2);

    // a,b,7,8,9,space
    cyc(1'b0, 1'b1, 4'd2, 4'd3, "a", "7");
    idle(7);

    // lowercase wrap y,z,a,space
    cyc(1'b0, 1'b1, 4'd3, 4'd0, "y", "x");
    idle(5);

    // uppercase wrap and digit wrap: Z,A,8,9,0,space
    cyc(1'b0, 1'b1, 4'd2, 4'd3, "Z", "8");
    idle(7);

    // rejected requests
    cyc(1'b0, 1'b1, 4'd0, 4'd1, "a", "1");
    idle(1);
    cyc(1'b0, 1'b1, 4'd2, 4'd0, "5", "1");
    idle(1);
    cyc(1'b0, 1'b1, 4'd1, 4'd2, "q", "x");
    idle(1);
    cyc(1'b0, 1'b1, 4'd1, 4'd0, "q", "x");   // digit base ignored: accepted
    idle(3);

    // start pulses while busy are ignored
    cyc(1'b0, 1'b1, 4'd5, 4'd2, "c", "4");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 4'd3, 4'd1, "m", "1");
    cyc(1'b0, 1'b1, 4'd0, 4'd0, "5", "x");
    idle(8);

    // reset while the second letter is on the output
    cyc(1'b0, 1'b1, 4'd4, 4'd2, "k", "2");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    idle(4);

    // start held: letter, digit, space repeating with no gap
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 4'd1, 4'd1, "p", "3");
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 2) == 0);
      ln = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      dn = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       bl = 8'($urandom_range(0, 255));
        1, 2:    bl = 8'(32'h41 + $urandom_range(0, 25));
        default: bl = 8'(32'h61 + $urandom_range(0, 25));
      endcase
      bd = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'(32'h30 + $urandom_range(0, 9));
      cyc(r, s, ln, dn, bl, bd);
    end
    idle(40);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
